ads1672_adc_emulator: RTL and testbench

//  Synthesizable stand-in for the ADS1672 ADC: the device side of the serial link read by the ADC controller.

---
 rtl/ads1672_adc_emulator.sv | 193 +++++++++++++++++++
 tb/tb_ads1672_adc_emulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ads1672_adc_emulator.sv
// ads1672_adc_emulator
//   Device-side model of an ADS1672 serial link. The controller drives START
//   and SCLK; the model answers with DRDY_n and DOUT. Each conversion word
//   comes either from an internal ramp or from an external parallel sample
//   stream.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   start          high = converting; low returns to IDLE on the next clk
//   sclk           serial clock from the controller (asynchronous to clk)
//   drdy_n, dout   data-ready (active low) and serial data, MSB first
//   use_ext        0 = internal ramp, 1 = sample_in stream
//   sample_in      external sample word
//   sample_valid   sample_in holds a valid word
//   sample_ready   1-clk pulse: sample_in consumed this cycle if valid
//   overrun        1-clk pulse: conversion dropped during a read
//   busy           high whenever the FSM is not in IDLE
module ads1672_adc_emulator #(
  parameter int DATA_WIDTH    = 24,
  parameter int PERIOD        = 64,
  parameter int SETTLE_CYCLES = 256,
  parameter int RAMP_STEP     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sclk,
  output logic                  drdy_n,
  output logic                  dout,
  input  logic                  use_ext,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [PW-1:0] PERIOD_TC = PW'(PERIOD - 1);
  localparam logic [SW-1:0] SETTLE_TC = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WAIT, S_CONV, S_READY, S_SHIFT
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            sclk_sync_q;
  logic [SW-1:0]         settle_cnt_q, settle_cnt_d;
  logic [PW-1:0]         period_cnt_q, period_cnt_d;
  logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  drdy_n_q, drdy_n_d;
  logic                  dout_q, dout_d;
  logic                  overrun_q, overrun_d;

  logic                  sclk_rise;
  logic                  period_tc;
  logic [DATA_WIDTH-1:0] conv_word;
  logic [DATA_WIDTH-1:0] ramp_next;

  // Two synchronizer flops plus one history flop for edge detection, so
  // dout moves on the third clk edge after the sclk pin rises.
  always_ff @(posedge clk) begin
    if (rst) sclk_sync_q <= '0;
    else     sclk_sync_q <= {sclk_sync_q[1:0], sclk};
  end
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];

  assign period_tc = (period_cnt_q == PERIOD_TC);
  assign ramp_next = ramp_q + DATA_WIDTH'(RAMP_STEP);
  // Stream source with no valid word repeats the previous word.
  assign conv_word = use_ext ? (sample_valid ? sample_in : word_q) : ramp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      period_cnt_q <= '0;
      ramp_q       <= '0;
      word_q       <= '0;
      bit_q        <= '0;
      drdy_n_q     <= 1'b1;
      dout_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      period_cnt_q <= period_cnt_d;
      ramp_q       <= ramp_d;
      word_q       <= word_d;
      bit_q        <= bit_d;
      drdy_n_q     <= drdy_n_d;
      dout_q       <= dout_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    period_cnt_d = period_cnt_q;
    ramp_d       = ramp_q;
    word_d       = word_q;
    bit_d        = bit_q;
    drdy_n_d     = drdy_n_q;
    dout_d       = dout_q;
    overrun_d    = 1'b0;

    // Conversion spacing is fixed once the first conversion happens: the
    // counter keeps wrapping regardless of what the reader does, and it sits
    // at zero in every CONV cycle.
    if (state_q inside {S_WAIT, S_CONV, S_READY, S_SHIFT})
      period_cnt_d = period_tc ? '0 : period_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        drdy_n_d     = 1'b1;
        dout_d       = 1'b0;
        settle_cnt_d = '0;
        period_cnt_d = '0;
        ramp_d       = '0;
        if (start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_TC) state_d = S_CONV;
        else                           settle_cnt_d = settle_cnt_q + 1'b1;
      end
      S_WAIT: begin
        if (period_tc) state_d = S_CONV;
      end
      S_CONV: begin
        word_d   = conv_word;
        dout_d   = conv_word[DATA_WIDTH-1];
        drdy_n_d = 1'b0;
        if (!use_ext) ramp_d = ramp_next;
        state_d  = S_READY;
      end
      S_READY: begin
        if (sclk_rise) begin
          drdy_n_d = 1'b1;
          dout_d   = word_q[DATA_WIDTH-2];
          bit_d    = BW'(DATA_WIDTH - 2);
          state_d  = S_SHIFT;
          // A conversion landing on the same clk as the first rise finds the
          // read already under way and is dropped.
          if (period_tc) begin
            overrun_d = 1'b1;
            if (!use_ext) ramp_d = ramp_next;
          end
        end else if (period_tc) begin
          // Unread word is simply replaced; drdy_n stays low.
          state_d = S_CONV;
        end
      end
      S_SHIFT: begin
        if (sclk_rise) begin
          if (bit_q == '0) begin
            dout_d  = 1'b0;
            state_d = S_WAIT;
          end else begin
            bit_d  = bit_q - 1'b1;
            dout_d = word_q[bit_q - 1'b1];
          end
        end
        if (period_tc) begin
          overrun_d = 1'b1;
          if (!use_ext) ramp_d = ramp_next;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping start abandons everything, including an in-flight read.
    if (!start) begin
      state_d      = S_IDLE;
      drdy_n_d     = 1'b1;
      dout_d       = 1'b0;
      overrun_d    = 1'b0;
      settle_cnt_d = '0;
      period_cnt_d = '0;
    end
  end

  assign sample_ready = (state_q == S_CONV) && use_ext && start;
  assign drdy_n       = drdy_n_q;
  assign dout         = dout_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ads1672_adc_emulator.sv
// Directed bench for ads1672_adc_emulator. The DUT runs with a 256-clk
// conversion period so an 8-clk sclk period can read a whole word between
// conversions; a 24-clk sclk period is used to force overruns.
module tb_ads1672_adc_emulator;

  localparam int DW     = 24;
  localparam int PER    = 256;
  localparam int SETTLE = 256;

  logic          clk = 1'b0;
  logic          rst, start, sclk, use_ext, sample_valid;
  logic [DW-1:0] sample_in;
  logic          drdy_n, dout, sample_ready, overrun, busy;

  int vectors     = 0;
  int miscompares = 0;
  int ovr_cnt     = 0;
  int rdy_cnt     = 0;

  ads1672_adc_emulator #(
    .DATA_WIDTH(DW), .PERIOD(PER), .SETTLE_CYCLES(SETTLE), .RAMP_STEP(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sclk(sclk),
    .drdy_n(drdy_n), .dout(dout), .use_ext(use_ext),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (overrun === 1'b1)      ovr_cnt <= ovr_cnt + 1;
    if (sample_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_drdy(input string tag, input int limit, output int n);
    n = 0;
    while (drdy_n !== 1'b0 && n < limit) begin
      tick(1);
      n++;
    end
    check({tag, "_drdy_timeout"}, 32'(n < limit), 32'd1);
  endtask

  // Shifts in the MSB already on dout, then issues nrises sclk rises.
  // sclk is left high; the caller lowers it.
  task automatic serial_read(input int half, input int nrises,
                             output logic [DW-1:0] w, output logic drdy_hi,
                             output logic last_dout);
    w         = '0;
    drdy_hi   = 1'b0;
    last_dout = 1'b0;
    w[DW-1]   = dout;
    for (int r = 1; r <= nrises; r++) begin
      sclk = 1'b1;
      tick(half);
      if (r == 1) drdy_hi = drdy_n;
      if (r <= DW - 1) w[DW-1-r] = dout;
      last_dout = dout;
      if (r < nrises) begin
        sclk = 1'b0;
        tick(half);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] w;
    logic          dh, ld, stay_low;
    int            n, ovr0, rdy0;

    rst = 1'b1; start = 1'b0; sclk = 1'b0; use_ext = 1'b0;
    sample_valid = 1'b0; sample_in = '0;
    tick(3);
    check("rst_drdy_n", 32'(drdy_n), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_sample_ready", 32'(sample_ready), 32'd0);
    rst = 1'b0;
    tick(2);

    // Settle time from START rise to first DRDY_n fall.
    start = 1'b1;
    wait_drdy("settle", SETTLE + 20, n);
    check("settle_cycles", 32'(n), 32'(SETTLE + 2));
    check("settle_busy", 32'(busy), 32'd1);
    check("first_msb", 32'(dout), 32'd0);

    // Full-rate reads of ramp words 0..3.
    ovr0 = ovr_cnt;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) wait_drdy("ramp", PER + 8, n);
      serial_read(4, DW, w, dh, ld);
      sclk = 1'b0;
      tick(4);
      $display("ramp read %0d: word=%06h drdy_after_rise1=%0b dout_after_24=%0b", k, w, dh, ld);
      check("ramp_word", 32'(w), 32'(k));
      check("ramp_drdy_hi", 32'(dh), 32'd1);
      check("ramp_tail_dout", 32'(ld), 32'd0);
    end
    check("ramp_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);

    // Slow read spans two conversions: both dropped, ramp skips 5 and 6.
    ovr0 = ovr_cnt;
    wait_drdy("slow", PER + 8, n);
    serial_read(12, DW, w, dh, ld);
    sclk = 1'b0;
    tick(12);
    $display("slow read: word=%06h overruns=%0d", w, ovr_cnt - ovr0);
    check("slow_word", 32'(w), 32'd4);
    check("slow_overruns", 32'(ovr_cnt - ovr0), 32'd2);
    wait_drdy("after_slow", PER + 8, n);
    serial_read(4, DW, w, dh, ld);
    sclk = 1'b0;
    tick(4);
    $display("after overrun: word=%06h", w);
    check("skip_word", 32'(w), 32'd7);

    // No read across two conversions: word overwritten, drdy_n held low.
    ovr0 = ovr_cnt;
    wait_drdy("idle_read", PER + 8, n);
    stay_low = 1'b1;
    for (int i = 0; i < 2 * PER + 20; i++) begin
      tick(1);
      if (drdy_n !== 1'b0) stay_low = 1'b0;
    end
    check("hold_drdy_low", 32'(stay_low), 32'd1);
    serial_read(4, DW, w, dh, ld);
    sclk = 1'b0;
    tick(4);
    $display("late read: word=%06h overruns=%0d", w, ovr_cnt - ovr0);
    check("latest_word", 32'(w), 32'd10);
    check("latest_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);

    // External stream: valid word, then repeat when not valid.
    use_ext = 1'b1; sample_in = 24'hA5F00F; sample_valid = 1'b1;
    rdy0 = rdy_cnt;
    wait_drdy("ext", PER + 8, n);
    serial_read(4, DW, w, dh, ld);
    sclk = 1'b0;
    tick(4);
    $display("ext read: word=%06h sample_ready_pulses=%0d", w, rdy_cnt - rdy0);
    check("ext_word", 32'(w), 32'hA5F00F);
    check("ext_ready_pulse", 32'(rdy_cnt - rdy0), 32'd1);
    sample_valid = 1'b0; sample_in = 24'h123456;
    wait_drdy("ext_rep", PER + 8, n);
    serial_read(4, DW, w, dh, ld);
    sclk = 1'b0;
    tick(4);
    $display("ext repeat read: word=%06h sample_ready_pulses=%0d", w, rdy_cnt - rdy0);
    check("ext_repeat_word", 32'(w), 32'hA5F00F);
    check("ext_ready_pulses", 32'(rdy_cnt - rdy0), 32'd2);

    // Abort after the 10th bit (dout = bit 13 of A5F00F = 1), then restart.
    wait_drdy("abort", PER + 8, n);
    serial_read(4, 10, w, dh, ld);
    check("abort_bit13", 32'(ld), 32'd1);
    start = 1'b0;
    tick(1);
    $display("abort: drdy_n=%0b dout=%0b busy=%0b", drdy_n, dout, busy);
    check("abort_drdy_n", 32'(drdy_n), 32'd1);
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    sclk = 1'b0; use_ext = 1'b0;
    tick(4);
    start = 1'b1;
    wait_drdy("restart", SETTLE + 20, n);
    check("restart_settle", 32'(n), 32'(SETTLE + 2));
    serial_read(4, DW, w, dh, ld);
    sclk = 1'b0;
    tick(4);
    $display("restart read: word=%06h", w);
    check("restart_word", 32'(w), 32'd0);

    // Reset in the middle of operation.
    wait_drdy("midrst", PER + 8, n);
    rst = 1'b1;
    tick(1);
    $display("mid reset: drdy_n=%0b dout=%0b busy=%0b", drdy_n, dout, busy);
    check("midrst_drdy_n", 32'(drdy_n), 32'd1);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
